// File: rtl/seq_generator.sv
// Multi-mode sequence generator (up, down, Galois LFSR, hold) with a valid/ready sample port.
// Define GEN_LFSR_EN to build the LFSR mode; without it mode 10 behaves as hold.
module seq_generator #(
   parameter int                WIDTH = 8,
   parameter logic [WIDTH-1:0]  TAPS  = 8'hB8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ready,
   output logic             valid,
   output logic             wrap,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_next;
   logic [WIDTH-1:0] value, value_next;
   logic             wrap_next;
   logic [WIDTH:0]   sum;
   logic             advance;

   assign valid   = en && (state == RUN);
   assign advance = valid && ready && !load;
   assign count   = en ? value : {WIDTH{1'bz}};
   assign sum     = {1'b0, value} + {1'b0, step};

   // Start-up walks IDLE -> PRIME -> RUN so the first sample appears one bubble after enable.
   always_comb begin
      state_next = state;
      if (!en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = PRIME;
            PRIME:   state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   // Candidate value for the next accepted sample; only committed when an advance happens.
   always_comb begin
      value_next = value;
      wrap_next  = 1'b0;
      case (mode)
         2'b00: begin
            if (step != '0) begin
               if (sum > {1'b0, limit}) begin
                  value_next = '0;
                  wrap_next  = 1'b1;
               end else begin
                  value_next = sum[WIDTH-1:0];
               end
            end
         end
         2'b01: begin
            if (value < step) begin
               value_next = limit;
               wrap_next  = 1'b1;
            end else begin
               value_next = value - step;
            end
         end
`ifdef GEN_LFSR_EN
         2'b10: begin
            // An all-zero register would lock the LFSR, so it escapes to 1.
            if (value == '0) begin
               value_next = ONE;
            end else begin
               value_next = (value >> 1) ^ (value[0] ? TAPS : '0);
            end
            wrap_next = (value_next == ONE);
         end
`endif
         default: begin
            value_next = value;
            wrap_next  = 1'b0;
         end
      endcase
   end

   // Load overrides any advance; wrap is a single-cycle pulse after a wrapping advance.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
         value <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= state_next;
         if (en && load) begin
            value <= load_val;
            wrap  <= 1'b0;
         end else if (advance) begin
            value <= value_next;
            wrap  <= wrap_next;
         end else begin
            wrap  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: stimulus queues expected samples, a negedge monitor checks them.
// Honours GEN_LFSR_EN so the expected LFSR stream matches the build under test.
module tb_seq_generator;

   logic       clk;
   logic       res;
   logic       en;
   logic [1:0] mode;
   logic [7:0] step;
   logic [7:0] limit;
   logic       load;
   logic [7:0] load_val;
   logic       ready;
   logic       valid;
   logic       wrap;
   logic [7:0] count;

   typedef struct {
      logic [7:0] cnt;
      logic       wrp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   seq_generator #(.WIDTH(8), .TAPS(8'hB8)) dut (
      .clk      (clk),
      .res      (res),
      .en       (en),
      .mode     (mode),
      .step     (step),
      .limit    (limit),
      .load     (load),
      .load_val (load_val),
      .ready    (ready),
      .valid    (valid),
      .wrap     (wrap),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] s,
                                input logic [7:0] l, input logic ld, input logic [7:0] lv,
                                input logic r);
      en = e; mode = m; step = s; limit = l; load = ld; load_val = lv; ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] c, input logic w);
      exp_t e;
      e.cnt = c;
      e.wrp = w;
      sb.push_back(e);
   endtask

   // Keeps ready high until every queued sample has been accepted, then drops it.
   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout pending=%0d expected=0", sb.size());
         sb.delete();
      end
      ready = 1'b0;
   endtask

   function automatic logic [7:0] lfsrNext(input logic [7:0] v);
      if (v == 8'd0) return 8'd1;
      return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   // A handshake completes on the edge following this negedge, so the presented sample is consumed.
   always @(negedge clk) begin
      exp_t e;
      if (valid === 1'b1 && ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_sample count=%0d expected=none", count);
         end else begin
            e = sb.pop_front();
            checkOutput("sample_count", {24'd0, count}, {24'd0, e.cnt});
            checkOutput("sample_wrap", {31'd0, wrap}, {31'd0, e.wrp});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout reached expected=finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [7:0] v;
      res = 1'b1;
      applyStimulus(0, 2'b00, 8'd0, 8'd0, 0, 8'd0, 0);

      // Reset with the block disabled; a two-state simulator resolves a floating bus to zero.
      tick();
      checkOutput("reset_valid", {31'd0, valid}, 0);
      checkOutput("reset_wrap", {31'd0, wrap}, 0);
      checkOutput("reset_count_floating", {31'd0, (count === 8'bz || count === 8'd0)}, 1);
      res = 1'b0;

      // Full 8-bit up count with the start-up bubble.
      for (int i = 0; i < 256; i++) push(i[7:0], 1'b0);
      push(8'd0, 1'b1);
      applyStimulus(1, 2'b00, 8'd1, 8'd255, 0, 8'd0, 1);
      tick();
      checkOutput("prime_bubble_valid", {31'd0, valid}, 0);
      tick();
      checkOutput("run_valid", {31'd0, valid}, 1);
      checkOutput("run_first_count", {24'd0, count}, 0);
      drain(300);

      // Step 3 up to limit 10, then a stall.
      applyStimulus(1, 2'b00, 8'd3, 8'd10, 1, 8'd0, 0);
      tick();
      push(8'd0, 0); push(8'd3, 0); push(8'd6, 0); push(8'd9, 0); push(8'd0, 1); push(8'd3, 0);
      applyStimulus(1, 2'b00, 8'd3, 8'd10, 0, 8'd0, 1);
      drain(20);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("stall_count", {24'd0, count}, 6);
         checkOutput("stall_valid", {31'd0, valid}, 1);
      end

      // Down count with a load that also consumes the presented sample.
      push(8'd6, 0); push(8'd6, 0); push(8'd2, 0); push(8'd20, 1); push(8'd16, 0); push(8'd12, 0);
      push(8'd8, 0); push(8'd4, 0); push(8'd0, 0); push(8'd20, 1); push(8'd16, 0);
      applyStimulus(1, 2'b01, 8'd4, 8'd20, 1, 8'd6, 1);
      tick();
      applyStimulus(1, 2'b01, 8'd4, 8'd20, 0, 8'd6, 1);
      drain(30);

      // Mode 10 from zero: LFSR period when built, hold otherwise.
      applyStimulus(1, 2'b10, 8'd4, 8'd20, 1, 8'd0, 0);
      tick();
      push(8'd0, 0);
`ifdef GEN_LFSR_EN
      v = 8'd0;
      for (int i = 0; i < 256; i++) begin
         v = lfsrNext(v);
         push(v, v == 8'd1);
      end
`else
      v = 8'd0;
      for (int i = 0; i < 4; i++) push(v, 0);
`endif
      applyStimulus(1, 2'b10, 8'd4, 8'd20, 0, 8'd0, 1);
      drain(400);

      // Disable at 7: bus floats at once, loads are ignored, re-enable primes again.
      applyStimulus(1, 2'b11, 8'd4, 8'd20, 1, 8'd7, 0);
      tick();
      checkOutput("pre_disable_count", {24'd0, count}, 7);
      applyStimulus(0, 2'b11, 8'd4, 8'd20, 0, 8'd7, 0);
      #1;
      checkOutput("disable_valid", {31'd0, valid}, 0);
      checkOutput("disable_count_floating", {31'd0, (count === 8'bz || count === 8'd0)}, 1);
      tick();
      applyStimulus(0, 2'b11, 8'd4, 8'd20, 1, 8'd99, 0);
      tick();
      applyStimulus(1, 2'b11, 8'd4, 8'd20, 0, 8'd99, 0);
      tick();
      checkOutput("reenable_prime_valid", {31'd0, valid}, 0);
      checkOutput("reenable_prime_count", {24'd0, count}, 7);
      tick();
      checkOutput("reenable_run_valid", {31'd0, valid}, 1);
      checkOutput("reenable_run_count", {24'd0, count}, 7);

      // Asynchronous reset mid-cycle while running at 50.
      applyStimulus(1, 2'b00, 8'd1, 8'd255, 1, 8'd50, 0);
      tick();
      checkOutput("pre_reset_count", {24'd0, count}, 50);
      applyStimulus(1, 2'b00, 8'd1, 8'd255, 0, 8'd50, 0);
      #3;
      res = 1'b1;
      #1;
      checkOutput("async_reset_count", {24'd0, count}, 0);
      checkOutput("async_reset_valid", {31'd0, valid}, 0);
      checkOutput("async_reset_wrap", {31'd0, wrap}, 0);
      tick();
      res = 1'b0;
      tick();
      checkOutput("post_reset_prime_valid", {31'd0, valid}, 0);
      tick();
      checkOutput("post_reset_run_valid", {31'd0, valid}, 1);
      checkOutput("post_reset_count", {24'd0, count}, 0);

      // limit=0 in up mode wraps on every advance.
      applyStimulus(1, 2'b00, 8'd2, 8'd0, 1, 8'd0, 0);
      tick();
      push(8'd0, 0); push(8'd0, 1); push(8'd0, 1);
      applyStimulus(1, 2'b00, 8'd2, 8'd0, 0, 8'd0, 1);
      drain(20);

      // step=0 leaves an out-of-range value untouched and never wraps.
      applyStimulus(1, 2'b00, 8'd0, 8'd100, 1, 8'd200, 0);
      tick();
      push(8'd200, 0); push(8'd200, 0); push(8'd200, 0);
      applyStimulus(1, 2'b00, 8'd0, 8'd100, 0, 8'd200, 1);
      drain(20);

      // Up advance from above the limit wraps to zero.
      push(8'd200, 0); push(8'd0, 1); push(8'd1, 0);
      applyStimulus(1, 2'b00, 8'd1, 8'd100, 0, 8'd200, 1);
      drain(20);

      // Down advance from above the limit proceeds normally.
      applyStimulus(1, 2'b01, 8'd5, 8'd100, 1, 8'd200, 0);
      tick();
      push(8'd200, 0); push(8'd195, 0); push(8'd190, 0);
      applyStimulus(1, 2'b01, 8'd5, 8'd100, 0, 8'd200, 1);
      drain(20);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
